// File: rtl/alu16_reg.sv
// alu16_reg: registered 16-bit ALU with Z/N/C/V flags; define ALU_SAT_EN to add a sat input for saturating ADD/SUB
module alu16_reg #(
  parameter int WIDTH = 16,
  parameter int SHW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       mode,
`ifdef ALU_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SHR = 3'd2, OP_SHL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_NOT = 3'd6, OP_XOR = 3'd7;
  logic [WIDTH:0] sum, diff, shr, shl;
  logic [WIDTH-1:0] res_d, out_q;
  logic c_d, v_d, add_v, sub_v, big;
  logic z_q, n_q, c_q, v_q, valid_q;
  assign sum   = {1'b0, in1} + {1'b0, in2};
  assign diff  = {1'b0, in1} - {1'b0, in2};
  assign add_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
  assign sub_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
  assign big   = |in2[WIDTH-1:SHW];
  assign shr   = {in1, 1'b0} >> in2[SHW-1:0];
  assign shl   = {1'b0, in1} << in2[SHW-1:0];
  // result and carry/overflow selection; the extra bit of shr/shl captures the last bit shifted out
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (mode)
      OP_ADD: begin res_d = sum[WIDTH-1:0]; c_d = sum[WIDTH]; v_d = add_v; end
      OP_SUB: begin res_d = diff[WIDTH-1:0]; c_d = diff[WIDTH]; v_d = sub_v; end
      OP_SHR: begin res_d = big ? '0 : shr[WIDTH:1]; c_d = !big && shr[0]; end
      OP_SHL: begin res_d = big ? '0 : shl[WIDTH-1:0]; c_d = !big && shl[WIDTH]; end
      OP_AND: res_d = in1 & in2;
      OP_OR:  res_d = in1 | in2;
      OP_NOT: res_d = ~in1;
      OP_XOR: res_d = in1 ^ in2;
      default: res_d = '0;
    endcase
`ifdef ALU_SAT_EN
    if (sat && v_d && (mode == OP_ADD || mode == OP_SUB))
      res_d = in1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end
  // capture result and flags on valid input; out_valid tracks in_valid with one cycle delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        out_q <= res_d;
        z_q   <= res_d == '0;
        n_q   <= res_d[WIDTH-1];
        c_q   <= c_d;
        v_q   <= v_d;
      end
    end
  end
  assign out       = out_q;
  assign out_valid = valid_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
endmodule

// File: tb/tb_alu16_reg.sv
// tb_alu16_reg: vector table, hand sequences and randomized model check for alu16_reg
module tb_alu16_reg;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sat = 1'b0;
  logic [15:0] in1 = '0, in2 = '0, out;
  logic [2:0] mode = '0;
  logic out_valid, flag_z, flag_n, flag_c, flag_v;
  int n_cmp = 0, n_fail = 0;

  typedef struct packed {
    logic [15:0] o;
    logic z, n, c, v;
  } res_t;

  typedef struct {
    logic [15:0] a, b;
    logic [2:0] m;
    logic [15:0] eo;
    logic ez, en, ec, ev;
  } vec_t;

  alu16_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2), .mode(mode),
`ifdef ALU_SAT_EN
    .sat(sat),
`endif
    .out(out), .out_valid(out_valid), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] m, input logic s);
    res_t r;
    int ua = int'(a), ub = int'(b), sa = int'($signed(a)), sb = int'($signed(b)), t = 0, st = 0;
    r = '0;
    case (m)
      3'd0: begin t = ua + ub; st = sa + sb; r.o = 16'(t); r.c = t > 65535; end
      3'd1: begin t = ua - ub; st = sa - sb; r.o = 16'(t); r.c = ua < ub; end
      3'd2: if (ub >= 16) r.o = 0; else if (ub == 0) r.o = a;
            else begin r.o = 16'(ua >> ub); r.c = ((ua >> (ub - 1)) & 1) == 1; end
      3'd3: if (ub >= 16) r.o = 0; else if (ub == 0) r.o = a;
            else begin r.o = 16'(ua << ub); r.c = ((ua >> (16 - ub)) & 1) == 1; end
      3'd4: r.o = a & b;
      3'd5: r.o = a | b;
      3'd6: r.o = ~a;
      default: r.o = a ^ b;
    endcase
    if (m < 2) r.v = st > 32767 || st < -32768;
`ifdef ALU_SAT_EN
    if (m < 2 && s && r.v) r.o = st > 0 ? 16'h7FFF : 16'h8000;
`endif
    r.z = r.o == 0;
    r.n = r.o[15];
    return r;
  endfunction

  task automatic check(input string name, input res_t e, input logic evld);
    n_cmp++;
    if ({out, flag_z, flag_n, flag_c, flag_v, out_valid} !== {e, evld}) begin
      n_fail++;
      $display("FAIL %s: got out=%h z%b n%b c%b v%b vld%b, expected out=%h z%b n%b c%b v%b vld%b",
               name, out, flag_z, flag_n, flag_c, flag_v, out_valid,
               e.o, e.z, e.n, e.c, e.v, evld);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                       input logic v, input logic s);
    in1 = a; in2 = b; mode = m; in_valid = v; sat = s;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  res_t exp_r, last;

  initial begin
    vecs.push_back('{16'd100, 16'd35, 3'd1, 16'h0041, 0, 0, 0, 0});
    vecs.push_back('{16'd0, 16'hFFFE, 3'd1, 16'h0002, 0, 0, 1, 0});
    vecs.push_back('{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1, 0, 1, 0});
    vecs.push_back('{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 0, 1, 0, 1});
    vecs.push_back('{16'h8000, 16'h0001, 3'd1, 16'h7FFF, 0, 0, 0, 1});
    vecs.push_back('{16'h8001, 16'd1, 3'd3, 16'h0002, 0, 0, 1, 0});
    vecs.push_back('{16'h8001, 16'd15, 3'd2, 16'h0001, 0, 0, 0, 0});
    vecs.push_back('{16'h00F0, 16'd4, 3'd2, 16'h000F, 0, 0, 0, 0});
    vecs.push_back('{16'h0003, 16'd1, 3'd2, 16'h0001, 0, 0, 1, 0});
    vecs.push_back('{16'h1234, 16'd16, 3'd3, 16'h0000, 1, 0, 0, 0});
    vecs.push_back('{16'hFFFF, 16'h0100, 3'd2, 16'h0000, 1, 0, 0, 0});
    vecs.push_back('{16'hABCD, 16'd0, 3'd3, 16'hABCD, 0, 1, 0, 0});
    vecs.push_back('{16'hF0F0, 16'hFF00, 3'd4, 16'hF000, 0, 1, 0, 0});
    vecs.push_back('{16'hF0F0, 16'hFF00, 3'd5, 16'hFFF0, 0, 1, 0, 0});
    vecs.push_back('{16'hF0F0, 16'hFF00, 3'd7, 16'h0FF0, 0, 0, 0, 0});
    vecs.push_back('{16'hF0F0, 16'hFF00, 3'd6, 16'h0F0F, 0, 0, 0, 0});

    // reset held with random active inputs
    for (int i = 0; i < 3; i++) issue(16'($urandom), 16'($urandom), 3'($urandom), 1'b1, 1'b0);
    check("reset", '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0, 16'h0, 3'd0, 1'b1, 1'b0);
    check("first_add", '{16'h0, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b1);

    // table vectors issued back to back
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].m, 1'b1, 1'b0);
      check($sformatf("vec%0d", i), '{vecs[i].eo, vecs[i].ez, vecs[i].en, vecs[i].ec, vecs[i].ev}, 1'b1);
    end

`ifdef ALU_SAT_EN
    issue(16'h7FFF, 16'h0001, 3'd0, 1'b1, 1'b1);
    check("sat_add_pos", '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b1);
    issue(16'h8000, 16'h0001, 3'd1, 1'b1, 1'b1);
    check("sat_sub_neg", '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}, 1'b1);
`endif

    // hold: in_valid low keeps result, clears out_valid
    issue(16'h1234, 16'h0001, 3'd0, 1'b1, 1'b0);
    last = '{16'h1235, 1'b0, 1'b0, 1'b0, 1'b0};
    check("pre_hold", last, 1'b1);
    issue(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0);
    check("hold1", last, 1'b0);
    issue(16'h0000, 16'h0000, 3'd6, 1'b0, 1'b0);
    check("hold2", last, 1'b0);

    // async reset pulse between edges
    issue(16'h7FFF, 16'h0001, 3'd0, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", '0, 1'b0);
    #1 rst_n = 1'b1;
    issue(16'h0005, 16'h0003, 3'd1, 1'b1, 1'b0);
    check("post_rst", '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);

    // randomized run against the reference model
    exp_r = '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a, b;
      logic [2:0] m;
      logic v, s;
      a = 16'($urandom);
      m = 3'($urandom);
      b = (m inside {3'd2, 3'd3} && $urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      v = $urandom_range(0, 4) != 0;
      s = 1'($urandom);
      if (v) exp_r = model(a, b, m, s);
      issue(a, b, m, v, s);
      check($sformatf("rand%0d", i), exp_r, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu16_reg.md
Name: alu16_reg

Overview:
- Single-cycle-latency, registered 16-bit integer ALU for the 16-bit processor datapath.
- Takes two operands and a 3-bit opcode from decode/register-file read.
- Produces a registered result plus Z/N/C/V status flags for the writeback stage and flag register.

Parameters:
- WIDTH, 16, operand/result width in bits; all values below assume 16.
- SHW, 4, shift-amount width, equal to log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/mode valid this cycle.
- in1  input  16  operand A.
- in2  input  16  operand B or shift amount.
- mode  input  3  opcode.
- out  output  16  registered result.
- out_valid  output  1  out/flags updated from the previous cycle's in_valid.
- flag_z  output  1  result is zero.
- flag_n  output  1  result bit 15.
- flag_c  output  1  carry / borrow / shifted-out bit.
- flag_v  output  1  signed overflow.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 SHIFTR, 3 SHIFTL, 4 AND, 5 OR, 6 NOT, 7 XOR.
- ADD: out = (in1 + in2) mod 2^16; C = carry out of bit 15; V = signed overflow (operands same sign, result sign differs).
- SUB: out = (in1 - in2) mod 2^16; C = borrow, 1 iff in1 < in2 unsigned; V = signed overflow (operands differ in sign, result sign differs from in1).
- SHIFTR: logical right shift of in1 by in2 (zero fill).
- SHIFTL: logical left shift of in1 by in2.
- Shift amounts:
  - 0 gives out = in1 and C = 0.
  - 1..15: C = last bit shifted out.
  - in2 >= 16 (any of bits 15..4 set): out = 0 and C = 0.
- AND / OR / XOR: bitwise on in1 and in2.
- NOT: out = ~in1; in2 ignored.
- Logic ops (AND, OR, NOT, XOR): C = 0, V = 0. Shifts: V = 0.
- Z = (out == 0) and N = out[15] for every opcode.
- Latency: combinational compute, registered on the rising clk edge when in_valid = 1. Result and flags are visible one cycle later with out_valid = 1.
- in_valid = 0: out and all flags hold their previous values; out_valid goes to 0 next edge.
- No backpressure. A new operation is accepted every cycle; back-to-back ops each produce a result the following cycle.
- Reset: rst_n low clears out, all four flags and out_valid to 0 immediately, independent of clk. Reset asserted mid-operation discards the pending result. The first edge after deassertion with in_valid = 1 computes normally.
- No X propagation from unused in2 for NOT; the result depends only on in1.

Optional Feature:
- Macro ALU_SAT_EN.
- When defined:
  - Adds input port sat (1 bit).
  - With sat = 1, ADD and SUB saturate on signed overflow: positive overflow gives 0x7FFF, negative overflow gives 0x8000.
  - V still reports that overflow occurred; C is computed from the unsaturated operation; Z/N follow the saturated result.
  - With sat = 0, results wrap normally.
- When undefined: the sat port does not exist and ADD/SUB always wrap.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> out = 0, all flags 0, out_valid = 0. Release rst_n, issue ADD 0+0 -> out = 0x0000, Z = 1, out_valid = 1 next cycle.
- SUB 100 - 35 -> out = 65 (0x0041), C = 0, V = 0, Z = 0, N = 0. SUB 0 - 65534 -> out = 2, C = 1 (borrow), V = 0.
- ADD 0xFFFF + 0x0001 -> out = 0, C = 1, Z = 1, V = 0. ADD 0x7FFF + 1 -> out = 0x8000, V = 1, N = 1; with ALU_SAT_EN and sat = 1 -> out = 0x7FFF, V = 1.
- Shifts:
  - SHIFTL 0x8001 by 1 -> 0x0002, C = 1.
  - SHIFTR 0x8001 by 15 -> 0x0001, C = 0.
  - SHIFTR 0x00F0 by 4 -> 0x000F, C = 0.
  - SHIFTL by 16 -> 0, C = 0.
- Logic ops with in1 = 0xF0F0, in2 = 0xFF00: AND -> 0xF000, OR -> 0xFFF0, XOR -> 0x0FF0, NOT -> 0x0F0F. C = 0 and V = 0 for all four.
- Pipeline: back-to-back ops with in_valid = 1 each cycle -> each result appears exactly one cycle later. Dropping in_valid -> out holds its value and out_valid = 0. Async rst_n pulse between edges -> outputs clear immediately.
